// File: rtl/bus_pkg.sv
// Shared bus definitions: instruction encodings, arbiter state encodings, watchdog width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

  typedef enum logic [1:0] {
    INSTR_NOP   = 2'b00,
    INSTR_WRITE = 2'b01,
    INSTR_RSVD  = 2'b10,
    INSTR_READ  = 2'b11
  } instr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int TO_W = 16;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: first requester searching upward from last+1, wrapping.
// Latency: combinational.
// Backpressure: none; valid low when no request is pending.
module rr_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic                   valid,
  output logic [IDX_W-1:0]       idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset down so the nearest requester after last wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = IDX_W'((int'(last) + i) % NUM_MASTERS);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with one-cycle release turnaround and grant watchdog.
// Latency: grant one edge after request is seen; release one edge after done/abort/timeout.
// Backpressure: a master waits with m_req high until granted; grant held until done, abort or timeout.
module bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1,
  parameter int TIMEOUT     = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_MASTERS-1:0] m_done,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [IDX_W-1:0]       owner,
  output logic                   bus_busy,
  output logic                   timeout
);

  import bus_pkg::*;

  localparam logic [TO_W-1:0]  TO_LAST   = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_MASTERS - 1);

  arb_state_t       state;
  logic [TO_W-1:0]  to_cnt;
  logic [IDX_W-1:0] last_owner;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_done;
  logic             owner_req;
  logic             wd_hit;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req   (m_req),
    .last  (last_owner),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // Only the current owner's handshake bits matter; everyone else is ignored.
  assign owner_done = m_done[owner];
  assign owner_req  = m_req[owner];
  assign wd_hit     = (TIMEOUT != 0) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      m_grant    <= '0;
      owner      <= '0;
      bus_busy   <= 1'b0;
      timeout    <= 1'b0;
      to_cnt     <= '0;
      last_owner <= LAST_INIT;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state      <= BUSY;
            m_grant    <= NUM_MASTERS'(1) << pick_idx;
            owner      <= pick_idx;
            last_owner <= pick_idx;
            bus_busy   <= 1'b1;
            to_cnt     <= '0;
          end
        end
        BUSY: begin
          // Done and abort outrank the watchdog, so a coinciding timeout is silent.
          if (owner_done || !owner_req) begin
            state    <= RELEASE;
            m_grant  <= '0;
            bus_busy <= 1'b0;
          end else if (wd_hit) begin
            state    <= RELEASE;
            m_grant  <= '0;
            bus_busy <= 1'b0;
            timeout  <= 1'b1;
          end else if ((TIMEOUT != 0) && (to_cnt != TO_LAST)) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          m_grant  <= '0;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (2 masters, watchdog of 8 cycles).
// Latency: n/a.
// Backpressure: n/a.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] m_req = 2'b00;
  logic [1:0] m_done = 2'b00;
  logic [1:0] m_grant;
  logic [0:0] owner;
  logic       bus_busy;
  logic       timeout;

  int n_chk = 0;
  int n_pass = 0;

  bus_arbiter #(
    .NUM_MASTERS (2),
    .IDX_W       (1),
    .TIMEOUT     (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_req    (m_req),
    .m_done   (m_done),
    .m_grant  (m_grant),
    .owner    (owner),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_seq [4];
  logic [1:0] prev_grant;
  int hi_cycles;
  logic dropped;

  initial begin
    exp_seq[0] = 2'b10;
    exp_seq[1] = 2'b01;
    exp_seq[2] = 2'b10;
    exp_seq[3] = 2'b01;

    // Reset values
    #12;
    chk("rst_grant", 16'(m_grant), 16'h0);
    chk("rst_owner", 16'(owner), 16'h0);
    chk("rst_busy", 16'(bus_busy), 16'h0);
    chk("rst_timeout", 16'(timeout), 16'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_grant", 16'(m_grant), 16'h0);

    // Both request: master 0 first, then master 1 after release + turnaround
    m_req = 2'b11;
    tick();
    chk("first_grant", 16'(m_grant), 16'h1);
    chk("first_owner", 16'(owner), 16'h0);
    chk("first_busy", 16'(bus_busy), 16'h1);
    tick(); tick(); tick();
    m_done = 2'b01;
    tick();
    m_done = 2'b00;
    chk("rel_grant", 16'(m_grant), 16'h0);
    chk("rel_busy", 16'(bus_busy), 16'h0);
    chk("rel_owner_kept", 16'(owner), 16'h0);
    chk("rel_timeout", 16'(timeout), 16'h0);
    tick();
    chk("turnaround_grant", 16'(m_grant), 16'h0);
    tick();
    chk("second_grant", 16'(m_grant), 16'h2);
    chk("second_owner", 16'(owner), 16'h1);

    // Fairness: each grant held 4 cycles, grants must alternate
    prev_grant = 2'b01;
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("fair_grant%0d", r), 16'(m_grant), 16'(exp_seq[r]));
      chk($sformatf("fair_alt%0d", r), 16'(m_grant != prev_grant), 16'h1);
      prev_grant = exp_seq[r];
      tick(); tick(); tick();
      m_done = exp_seq[r];
      tick();
      m_done = 2'b00;
      chk($sformatf("fair_rel%0d", r), 16'(m_grant), 16'h0);
      tick(); tick();
    end

    // Abort by master 1 (request drop, no done)
    chk("pre_abort_grant", 16'(m_grant), 16'h2);
    m_req = 2'b01;
    tick();
    chk("abort1_grant", 16'(m_grant), 16'h0);
    chk("abort1_timeout", 16'(timeout), 16'h0);
    tick(); tick();
    chk("after_abort_grant", 16'(m_grant), 16'h1);
    chk("after_abort_owner", 16'(owner), 16'h0);

    // Abort by master 0 at cycle 3 of its grant
    tick(); tick();
    m_req = 2'b00;
    tick();
    chk("abort0_grant", 16'(m_grant), 16'h0);
    chk("abort0_busy", 16'(bus_busy), 16'h0);
    chk("abort0_timeout", 16'(timeout), 16'h0);
    chk("abort0_owner", 16'(owner), 16'h0);
    tick(); tick();
    chk("noreq_idle_grant", 16'(m_grant), 16'h0);

    // Watchdog: master 0 never completes; master 1's done is ignored
    m_req = 2'b01;
    tick();
    chk("wd_grant", 16'(m_grant), 16'h1);
    hi_cycles = 1;
    m_req = 2'b11;
    m_done = 2'b10;
    tick();
    m_done = 2'b00;
    chk("ign_done_grant", 16'(m_grant), 16'h1);
    chk("ign_done_owner", 16'(owner), 16'h0);
    if (m_grant == 2'b01) hi_cycles++;
    dropped = 1'b0;
    for (int i = 0; i < 20 && !dropped; i++) begin
      tick();
      if (m_grant == 2'b01) hi_cycles++;
      else dropped = 1'b1;
    end
    chk("wd_dropped", 16'(dropped), 16'h1);
    chk("wd_hi_cycles", 16'(hi_cycles), 16'd8);
    chk("wd_timeout_pulse", 16'(timeout), 16'h1);
    chk("wd_grant_low", 16'(m_grant), 16'h0);
    tick();
    chk("wd_timeout_one_cycle", 16'(timeout), 16'h0);
    tick();
    chk("wd_next_grant", 16'(m_grant), 16'h2);
    chk("wd_next_owner", 16'(owner), 16'h1);

    // Done, request drop and watchdog all on the same edge: silent single release
    for (int i = 0; i < 7; i++) tick();
    chk("coinc_pre_grant", 16'(m_grant), 16'h2);
    m_done = 2'b10;
    m_req = 2'b01;
    tick();
    m_done = 2'b00;
    chk("coinc_grant", 16'(m_grant), 16'h0);
    chk("coinc_timeout", 16'(timeout), 16'h0);
    tick();
    chk("coinc_timeout_next", 16'(timeout), 16'h0);
    tick();
    chk("coinc_next_grant", 16'(m_grant), 16'h1);

    // Reset mid-transaction, with master 1 owning
    m_req = 2'b11;
    m_done = 2'b01;
    tick();
    m_done = 2'b00;
    tick(); tick();
    chk("pre_reset_owner", 16'(owner), 16'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_grant", 16'(m_grant), 16'h0);
    chk("async_rst_owner", 16'(owner), 16'h0);
    chk("async_rst_busy", 16'(bus_busy), 16'h0);
    chk("async_rst_timeout", 16'(timeout), 16'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_grant", 16'(m_grant), 16'h1);
    chk("post_rst_owner", 16'(owner), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the serial system bus among `NUM_MASTERS` master ports. Each master port raises a request before it starts a transaction. The arbiter grants exactly one master at a time and holds the grant until that master signals completion, drops its request, or overruns a watchdog timeout. It sits between the master ports and the bus mux, and it drives the mux select.

## Interface
Parameters:
- `NUM_MASTERS`, default 2: number of requesting masters. Legal range is 2–8.
- `IDX_W`, default 1: width of the owner index. Must equal ceil(log2(NUM_MASTERS)).
- `TIMEOUT`, default 1000: maximum number of cycles a grant may be held. The value 0 disables the watchdog. The counter is 16 bits wide.

Ports:
- `clk`  in  1  bus clock.
- `reset`  in  1  asynchronous reset, active-high.
- `m_req`  in  NUM_MASTERS  per-master request. Level-sensitive; a master holds it high for the whole transaction.
- `m_done`  in  NUM_MASTERS  per-master one-cycle completion pulse. This is the master's tx_done for writes and rx_done for reads.
- `m_grant`  out  NUM_MASTERS  one-hot grant, registered.
- `owner`  out  IDX_W  index of the current or most recent owner. This is the bus mux select.
- `bus_busy`  out  1  high while any grant is asserted.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- States:
  - IDLE: no grant; arbitrates.
  - BUSY: one grant held.
  - RELEASE: one turnaround cycle with no grant.
- Reset values:
  - state = IDLE, `m_grant` = 0, `bus_busy` = 0, `owner` = 0, `timeout` = 0, timeout counter = 0.
  - Internal `last_owner` = NUM_MASTERS-1, so master 0 wins the first arbitration.
- IDLE:
  - If `m_req` ≠ 0, pick the winner as the first requesting index searching upward from `last_owner`+1, modulo NUM_MASTERS.
  - Next state is BUSY. Set `m_grant[winner]`, `owner` = winner, `last_owner` = winner, `bus_busy` = 1, counter = 0.
  - If `m_req` = 0, remain in IDLE with all outputs unchanged.
- BUSY, evaluated in priority order:
  1. `m_done[owner]` = 1 → RELEASE.
  2. `m_req[owner]` = 0 → RELEASE (the master aborted).
  3. TIMEOUT ≠ 0 and counter = TIMEOUT-1 → RELEASE, and pulse `timeout` for one cycle.
  4. Otherwise stay in BUSY and increment the counter.
- Entering RELEASE: `m_grant` = 0 and `bus_busy` = 0. `owner` keeps its value so the bus mux stays stable.
- RELEASE → IDLE unconditionally. No arbitration happens in RELEASE.
- `m_done` and `m_req` bits from non-owners are ignored in every state.
- Done and request-drop in the same cycle cause a single release. If the timeout would fire in that same cycle, `timeout` is NOT pulsed, because done has priority.
- An owner that keeps `m_req` high after release re-competes in IDLE. Because of the round-robin order, it has the lowest priority.
- The counter saturates at TIMEOUT-1 and never wraps. When TIMEOUT = 0 the counter is held at 0.
- Reset asserted mid-transaction forces the reset values immediately, asynchronously. No `timeout` pulse is generated.

## Timing
- Grant latency: `m_req` first seen high at edge k → `m_grant` high after edge k+1.
- Release latency: `m_done` high at edge k → `m_grant` low after edge k+1, with the state in RELEASE.
- Minimum back-to-back gap: a new grant is asserted after edge k+3. This gives at least 1 idle bus cycle between owners.
- Watchdog:
  - A grant is held for at most TIMEOUT cycles.
  - `timeout` is high in the same cycle that `m_grant` drops.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `bus_pkg` holds:
  - the instruction encodings (2'b11 = read, etc.);
  - the arbiter state encodings IDLE=0, BUSY=1, RELEASE=2;
  - the counter width constant TO_W = 16.
- One combinational sub-module, `rr_picker`. Inputs are `req` [NUM_MASTERS] and `last` [IDX_W]. Outputs are `valid` and `idx` [IDX_W].
- The FSM, the counter and the output registers live in `bus_arbiter`.

## Test plan
- Reset, then NUM_MASTERS=2 with `m_req`=2'b11 at cycle 0 → `m_grant`=2'b01 at cycle 1, `owner`=0. After `m_done[0]` at cycle 5: `m_grant`=0 at cycle 6, then `m_grant`=2'b10 at cycle 8 with `owner`=1.
- Fairness: both requests held high with a done every 4 cycles of grant → grants alternate 01,10,01,10. No master is granted twice in a row.
- Abort: `m_req[0]` dropped at cycle 3 of its grant, with no done → grant drops the next cycle and `timeout` stays 0.
- Watchdog with TIMEOUT=8: the owner never pulses done → `m_grant` is high for exactly 8 cycles, then drops with `timeout` pulsed for 1 cycle. The next requester is granted 2 cycles later.
- Ignored inputs: `m_done[1]` pulsed while master 0 owns the bus → no state change. Done and timeout coinciding on the owner → release with `timeout`=0.
- Reset asserted while in BUSY → all outputs return to reset values without a clock edge. The first grant after reset goes to master 0.
